// File: rtl/tetris_move_scheduler.sv
// Motion-request scheduler for the Tetris game FSM: input conditioning, gravity tick, and
// priority arbitration onto a single valid/ready command channel. Optional: AUTOREPEAT_EN.
module tetris_move_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BASE_PERIOD     = 50000000,
    parameter int unsigned FAST_PERIOD     = 5000000,
    parameter int unsigned LEVEL_STEP      = 3000000,
    parameter int unsigned LEVEL_SHIFT     = 2,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic       rotate_sw,
    input  logic       drop_sw,
    input  logic       line_clear,
    input  logic       new_piece,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       quick_fall,
    output logic [3:0] level
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StIdle, StOffer} state_e;

    // Input bit order: 0 left, 1 right, 2 rotate, 3 drop
    logic [3:0]     raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     deb_q, deb_d, deb_prev_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];
    logic [3:0]     evt_q, evt_d;
    logic [1:0]     rep_evt;

    // Pending bit order: 0 down, 1 left, 2 right, 3 rotate (code = index + 1)
    logic [3:0]  pend_q, pend_d, req;
    logic        qf_q, qf_d;
    logic [7:0]  lines_q, lines_d, lines_shift;
    logic [3:0]  level_q, level_d;
    logic [31:0] grav_q, grav_d, period, step_total;
    logic        tick;
    state_e      state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic        handshake;

    assign raw = {drop_sw, rotate_sw, right_btn, left_btn};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    logic [31:0] rep_cnt_q [2];
    logic [31:0] rep_cnt_d [2];
    logic [1:0]  rep_armed_q, rep_armed_d;

    // Holding both buttons suppresses repeat on either side
    always_comb begin
        rep_evt = '0;
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i]   = rep_cnt_q[i] + 32'd1;
            rep_armed_d[i] = rep_armed_q[i];
            if (!(deb_q[i] && !deb_q[1-i])) begin
                rep_cnt_d[i]   = '0;
                rep_armed_d[i] = 1'b0;
            end else if (rep_cnt_q[i] >=
                         (rep_armed_q[i] ? REPEAT_RATE : REPEAT_DELAY) - 32'd1) begin
                rep_evt[i]     = 1'b1;
                rep_cnt_d[i]   = '0;
                rep_armed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q[0] <= '0;
            rep_cnt_q[1] <= '0;
            rep_armed_q  <= '0;
        end else begin
            rep_cnt_q[0] <= rep_cnt_d[0];
            rep_cnt_q[1] <= rep_cnt_d[1];
            rep_armed_q  <= rep_armed_d;
        end
    end
`else
    assign rep_evt = '0;
`endif

    always_comb begin
        evt_d[0]   = (deb_prev_q[0] & ~deb_q[0]) | rep_evt[0];
        evt_d[1]   = (deb_prev_q[1] & ~deb_q[1]) | rep_evt[1];
        evt_d[3:2] = deb_prev_q[3:2] ^ deb_q[3:2];
    end

    // Period floors at FAST_PERIOD before the subtraction can underflow
    always_comb begin
        step_total = 32'(level_q) * LEVEL_STEP;
        if (qf_q) begin
            period = FAST_PERIOD;
        end else if ((step_total < BASE_PERIOD) && (BASE_PERIOD - step_total > FAST_PERIOD)) begin
            period = BASE_PERIOD - step_total;
        end else begin
            period = FAST_PERIOD;
        end
        tick   = enable && (grav_q >= period - 32'd1);
        grav_d = (!enable || tick) ? 32'd0 : grav_q + 32'd1;
    end

    always_comb begin
        lines_d = lines_q;
        if (line_clear && (lines_q != 8'hff)) begin
            lines_d = lines_q + 8'd1;
        end
        lines_shift = lines_d >> LEVEL_SHIFT;
        level_d     = (lines_shift > 8'd15) ? 4'd15 : lines_shift[3:0];
    end

    always_comb begin
        qf_d = qf_q;
        if (new_piece) begin
            qf_d = 1'b0;
        end
        if (evt_q[3]) begin
            qf_d = 1'b1;
        end
        if (!enable) begin
            qf_d = 1'b0;
        end
    end

    assign handshake = (state_q == StOffer) && cmd_ready;
    assign req       = {evt_q[2], evt_q[1], evt_q[0], tick};

    // A fresh event in the handshake cycle re-arms the flag being cleared
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 4; i++) begin
            if (handshake && (code_q == 3'(i + 1))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d = pend_d | req;
        if (!enable) begin
            pend_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (enable && (|pend_q)) begin
                    state_d = StOffer;
                    if (pend_q[0]) begin
                        code_d = 3'd1;
                    end else if (pend_q[1]) begin
                        code_d = 3'd2;
                    end else if (pend_q[2]) begin
                        code_d = 3'd3;
                    end else begin
                        code_d = 3'd4;
                    end
                end
            end
            StOffer: begin
                if (cmd_ready) begin
                    state_d = StIdle;
                    code_d  = 3'd0;
                end
            end
        endcase
        if (!enable) begin
            state_d = StIdle;
            code_d  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            evt_q      <= '0;
            pend_q     <= '0;
            qf_q       <= 1'b0;
            lines_q    <= '0;
            level_q    <= '0;
            grav_q     <= '0;
            state_q    <= StIdle;
            code_q     <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            evt_q      <= evt_d;
            pend_q     <= pend_d;
            qf_q       <= qf_d;
            lines_q    <= lines_d;
            level_q    <= level_d;
            grav_q     <= grav_d;
            state_q    <= state_d;
            code_q     <= code_d;
        end
    end

    assign cmd_valid  = (state_q == StOffer);
    assign cmd_code   = code_q;
    assign quick_fall = qf_q;
    assign level      = level_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Self-checking bench for tetris_move_scheduler: directed sequences, a level/period vector
// table and a randomized phase against an arithmetic reference model.
module tb_tetris_move_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, left_btn, right_btn, rotate_sw, drop_sw, line_clear, new_piece;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       quick_fall;
    logic [3:0] level;

    tetris_move_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .BASE_PERIOD    (100),
        .FAST_PERIOD    (10),
        .LEVEL_STEP     (20),
        .LEVEL_SHIFT    (2),
        .REPEAT_DELAY   (30),
        .REPEAT_RATE    (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .left_btn  (left_btn),
        .right_btn (right_btn),
        .rotate_sw (rotate_sw),
        .drop_sw   (drop_sw),
        .line_clear(line_clear),
        .new_piece (new_piece),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .quick_fall(quick_fall),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pulses;
        int exp_level;
        int exp_period;
    } lvl_vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_total = 0;
    int hs_by_code [8];
    int last_hs_cyc;
    logic [2:0] last_hs_code;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Advance one cycle; log handshakes and check channel invariants on the way
    task automatic step();
        logic       hs, hold;
        logic [2:0] code_pre;
        hs       = cmd_valid && cmd_ready && enable && rst_n;
        hold     = cmd_valid && !cmd_ready && enable && rst_n;
        code_pre = cmd_code;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            hs_total++;
            hs_by_code[code_pre]++;
            last_hs_cyc  = cyc;
            last_hs_code = code_pre;
        end
        if (rst_n) begin
            if (!cmd_valid) check("code_zero_when_idle", 32'(cmd_code), 0);
            if (hold) begin
                check("offer_held_valid", 32'(cmd_valid), 1);
                check("offer_held_code", 32'(cmd_code), 32'(code_pre));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_hs(input int bound, output int c, output logic [2:0] code);
        int start, n;
        start = hs_total;
        n = 0;
        while (hs_total == start && n < bound) begin
            step();
            n++;
        end
        if (hs_total == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: got none in %0d cycles, expected one", bound);
            c    = cyc;
            code = 3'd0;
        end else begin
            c    = last_hs_cyc;
            code = last_hs_code;
        end
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!cmd_valid && n < bound) begin
            step();
            n++;
        end
        check("wait_valid", 32'(cmd_valid), 1);
    endtask

    // Measures the gap between the 2nd and 3rd DOWN handshakes from now
    task automatic measure_down_gap(input int bound, input string name, input int exp_gap);
        int c0, c1, c2;
        logic [2:0] k0, k1, k2;
        wait_hs(bound, c0, k0);
        wait_hs(bound, c1, k1);
        wait_hs(bound, c2, k2);
        check({name, "_code"}, 32'(k2), 1);
        check({name, "_gap"}, 32'(c2 - c1), 32'(exp_gap));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        left_btn   = 1'b0;
        right_btn  = 1'b0;
        rotate_sw  = 1'b0;
        drop_sw    = 1'b0;
        line_clear = 1'b0;
        new_piece  = 1'b0;
        cmd_ready  = 1'b0;
        steps(3);
        check("reset_valid", 32'(cmd_valid), 0);
        check("reset_code", 32'(cmd_code), 0);
        check("reset_quick_fall", 32'(quick_fall), 0);
        check("reset_level", 32'(level), 0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_lines(input int n);
        line_clear = 1'b1;
        steps(n);
        line_clear = 1'b0;
    endtask

    lvl_vec_t vecs [8];

    initial begin
        int c0, c1, c2, n2, base;
        logic [2:0] k0, k1, k2;
        int lines_model, exp_lvl, n_toggles, rot_before, next_rot;
        logic lc;

        vecs[0] = '{0, 0, 100};
        vecs[1] = '{4, 1, 80};
        vecs[2] = '{8, 2, 60};
        vecs[3] = '{12, 3, 40};
        vecs[4] = '{16, 4, 20};
        vecs[5] = '{20, 5, 10};
        vecs[6] = '{60, 15, 10};
        vecs[7] = '{300, 15, 10};
        for (int i = 0; i < 8; i++) hs_by_code[i] = 0;

        // Plain gravity at level 0
        do_reset();
        enable    = 1'b1;
        cmd_ready = 1'b1;
        wait_hs(150, c0, k0);
        wait_hs(150, c1, k1);
        wait_hs(150, c2, k2);
        check("gravity_code", 32'(k1), 1);
        check("gravity_gap1", 32'(c1 - c0), 100);
        check("gravity_gap2", 32'(c2 - c1), 100);
        check("gravity_quick_fall", 32'(quick_fall), 0);
        check("gravity_level", 32'(level), 0);
        check("gravity_other_codes", 32'(hs_by_code[2] + hs_by_code[3] + hs_by_code[4]), 0);

        // Debounce rejects a short pulse; a held press fires once on release
        n2 = hs_by_code[2];
        left_btn = 1'b1;
        steps(3);
        left_btn = 1'b0;
        steps(20);
        check("short_pulse_no_left", 32'(hs_by_code[2]), 32'(n2));
        left_btn = 1'b1;
        steps(10);
        check("press_no_left", 32'(hs_by_code[2]), 32'(n2));
        left_btn = 1'b0;
        steps(25);
        check("release_one_left", 32'(hs_by_code[2]), 32'(n2 + 1));

        // DOWN on offer is held while LEFT arrives behind it
        cmd_ready = 1'b0;
        left_btn  = 1'b1;
        steps(10);
        wait_valid(150);
        check("held_first_code", 32'(cmd_code), 1);
        left_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_valid", 32'(cmd_valid), 1);
            check("stall_code", 32'(cmd_code), 1);
        end
        cmd_ready = 1'b1;
        wait_hs(5, c0, k0);
        wait_hs(5, c1, k1);
        check("after_stall_first", 32'(k0), 1);
        check("after_stall_second", 32'(k1), 2);
        check("back_to_back_gap", 32'(c1 - c0), 2);

        // Quick fall: either switch edge enables it, new_piece cancels it
        do_reset();
        enable    = 1'b1;
        cmd_ready = 1'b1;
        steps(30);
        drop_sw = 1'b1;
        steps(12);
        check("drop_rise_quick_fall", 32'(quick_fall), 1);
        measure_down_gap(30, "fast", 10);
        new_piece = 1'b1;
        step();
        new_piece = 1'b0;
        check("new_piece_clears", 32'(quick_fall), 0);
        measure_down_gap(250, "restored", 100);
        drop_sw = 1'b0;
        steps(12);
        check("drop_fall_quick_fall", 32'(quick_fall), 1);

        // Level and period table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            enable    = 1'b1;
            cmd_ready = 1'b1;
            pulse_lines(vecs[v].pulses);
            check($sformatf("level_after_%0d", vecs[v].pulses), 32'(level),
                  32'(vecs[v].exp_level));
            measure_down_gap(250, $sformatf("period_after_%0d", vecs[v].pulses),
                             vecs[v].exp_period);
        end

        // Dropping enable during an offer abandons it and flushes every request
        do_reset();
        enable  = 1'b1;
        drop_sw = 1'b1;
        steps(12);
        left_btn = 1'b1;
        steps(8);
        left_btn = 1'b0;
        steps(12);
        wait_valid(50);
        enable = 1'b0;
        step();
        check("disable_valid", 32'(cmd_valid), 0);
        check("disable_code", 32'(cmd_code), 0);
        check("disable_quick_fall", 32'(quick_fall), 0);
        steps(5);
        enable    = 1'b1;
        cmd_ready = 1'b1;
        base = hs_total;
        steps(95);
        check("flushed_no_command", 32'(hs_total), 32'(base));
        wait_hs(20, c0, k0);
        check("first_after_reenable", 32'(k0), 1);

        // Asynchronous reset mid-offer
        do_reset();
        enable = 1'b1;
        pulse_lines(8);
        drop_sw = 1'b1;
        steps(12);
        wait_valid(30);
        check("pre_reset_level", 32'(level), 2);
        check("pre_reset_quick_fall", 32'(quick_fall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(cmd_valid), 0);
        check("async_reset_code", 32'(cmd_code), 0);
        check("async_reset_quick_fall", 32'(quick_fall), 0);
        check("async_reset_level", 32'(level), 0);
        steps(2);

        // Randomized: level model and rotate-toggle scoreboard
        do_reset();
        enable      = 1'b1;
        lines_model = 0;
        n_toggles   = 0;
        rot_before  = hs_by_code[4];
        next_rot    = 20;
        for (int i = 0; i < 800; i++) begin
            cmd_ready  = ($urandom % 4) != 0;
            lc         = ($urandom % 3) == 0;
            line_clear = lc;
            next_rot--;
            if (next_rot == 0) begin
                rotate_sw = ~rotate_sw;
                n_toggles++;
                next_rot = 15 + int'($urandom_range(0, 10));
            end
            step();
            if (lc && lines_model < 255) lines_model++;
            exp_lvl = lines_model / 4;
            if (exp_lvl > 15) exp_lvl = 15;
            check("rand_level", 32'(level), 32'(exp_lvl));
        end
        line_clear = 1'b0;
        cmd_ready  = 1'b1;
        steps(40);
        check("rand_rotate_count", 32'(hs_by_code[4] - rot_before), 32'(n_toggles));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_move_scheduler.md
# tetris_move_scheduler

Sequences all motion requests into the Tetris game state machine. Conditions the raw left/right buttons and the rotate/drop switches, generates the level-dependent gravity tick, and arbitrates these requesters onto a single valid/ready command channel. The game FSM executes one command at a time. The block sits between board I/O and the game FSM and replaces the FSM's internal fall counter and edge detectors.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronized input must stay stable before it is accepted (10 ms at 50 MHz).
- BASE_PERIOD, 50000000: gravity period in cycles at level 0.
- FAST_PERIOD, 5000000: gravity period in quick-fall mode; also the floor for every level.
- LEVEL_STEP, 3000000: period reduction per level.
- LEVEL_SHIFT, 2: level = lines_cleared >> LEVEL_SHIFT, saturating at 15.
- REPEAT_DELAY, 15000000 and REPEAT_RATE, 5000000: auto-repeat timing; used only under AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  game is in its play phase (spawn through evaluate).
- left_btn, right_btn  in  1  raw buttons, asynchronous.
- rotate_sw, drop_sw  in  1  raw switches, asynchronous; each toggle is one request.
- line_clear  in  1  one-cycle pulse per completed row.
- new_piece  in  1  one-cycle pulse when a block spawns.
- cmd_valid  out  1  command offered.
- cmd_code  out  3  command code: 1 = DOWN, 2 = LEFT, 3 = RIGHT, 4 = ROTATE; 0 whenever cmd_valid is low.
- cmd_ready  in  1  the FSM accepts the command (it is idle in its move state).
- quick_fall  out  1  fast gravity is active.
- level  out  4  current level.

## Operation
- Each raw input passes through a 2-FF synchronizer and then a debounce counter. The debounced value updates only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized value.
- Events are one cycle wide:
  - LEFT and RIGHT fire on the falling edge of the debounced button (on release).
  - ROTATE and DROP fire on either edge of the debounced switch.
- Each of DOWN, LEFT, RIGHT and ROTATE has a pending flag. An event sets its flag. A second event while the flag is set is coalesced (it does not count twice).
- DROP does not produce a command. It sets quick_fall. new_piece clears quick_fall.
- Gravity counter:
  - It counts only while enable is high.
  - When it reaches period−1 it sets pending DOWN and restarts at 0.
  - period = FAST_PERIOD if quick_fall is high; otherwise max(FAST_PERIOD, BASE_PERIOD − level·LEVEL_STEP). Use 32-bit unsigned arithmetic and clamp at the floor before any underflow.
  - A change of period does not reset the counter. If the counter is already ≥ period−1, the tick fires on the next cycle.
- Level tracking: an 8-bit lines counter increments on line_clear and saturates at 255. level = min(lines >> LEVEL_SHIFT, 15).
- Arbiter state machine:
  - IDLE: cmd_valid = 0. If enable is high and any flag is pending, latch the highest-priority request (DOWN > LEFT > RIGHT > ROTATE) into cmd_code and go to OFFER.
  - OFFER: cmd_valid = 1 and cmd_code is held stable even if a higher-priority request arrives. On cmd_valid & cmd_ready, clear that request's pending flag and return to IDLE.
- If a new event for the granted request type arrives in the handshake cycle, the new event wins and the flag stays set.
- When enable goes low:
  - Clear all pending flags and quick_fall.
  - Hold the gravity counter at 0.
  - Force the arbiter to IDLE. This is the only case in which cmd_valid drops without a handshake.
- Debouncers keep running regardless of enable.
- Reset values: cmd_valid = 0, cmd_code = 0, quick_fall = 0, level = 0. Lines counter, gravity counter and all flags = 0. Debounced values = 0. Arbiter in IDLE. Reset mid-handshake abandons the command.

## Timing
- Raw edge to event: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Event to pending flag: 1 cycle.
- Pending flag to cmd_valid: 1 cycle.
- Handshake to next cmd_valid: at least 1 IDLE cycle, so the maximum throughput is one command per 2 cycles.
- The gravity tick sets pending DOWN 1 cycle after the counter reaches period−1.
- line_clear to updated level: 1 cycle.
- All outputs are registered.

## Configuration
- AUTOREPEAT_EN defined: while debounced LEFT or RIGHT is held high, pending is set after REPEAT_DELAY cycles and then every REPEAT_RATE cycles. The release edge still fires once. Holding both buttons repeats neither.
- AUTOREPEAT_EN undefined: only release edges generate LEFT and RIGHT. The repeat counters are not built.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, BASE_PERIOD = 100, FAST_PERIOD = 10, LEVEL_STEP = 20, LEVEL_SHIFT = 2.
- Reset then enable = 1, cmd_ready = 1, no inputs: cmd_valid with code 1 every 100 cycles. All other outputs stay 0.
- left_btn pulsed for 3 cycles: no command. left_btn held 10 cycles then released: exactly one code 2.
- Left release and gravity tick pending together, cmd_ready = 0 for 20 cycles: code 1 is held stable throughout. Code 2 follows after cmd_ready rises.
- Toggle drop_sw: quick_fall = 1 and DOWN every 10 cycles. A new_piece pulse restores the 100-cycle period.
- 8 line_clear pulses: level = 2 and the period is 60. 60 pulses: level = 15 and the period is clamped to 10.
- Drop enable low during OFFER: cmd_valid is 0 on the next cycle and all flags are cleared. Assert rst_n low mid-count: all outputs are 0 immediately.
